// File: rtl/pipelined_cla_adder.sv
// pipelined_cla_adder: bubble-collapsing pipelined carry-lookahead adder/subtractor.
// Each stage resolves WIDTH/STAGES result bits with 4-bit lookahead groups.
module pipelined_cla_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ans,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);
    localparam int SW = WIDTH / STAGES;
    localparam logic [STAGES-1:0] ALL = '1;

    // returns {carry into slice MSB, carry out of slice, slice sum}
    function automatic logic [SW+1:0] cla_slice(input logic [SW-1:0] x, input logic [SW-1:0] y,
                                                 input logic ci);
        logic [SW-1:0] g, p;
        logic [SW:0] c;
        g = x & y;
        p = x ^ y;
        c = '0;
        c[0] = ci;
        for (int j = 0; j < SW; j += 4) begin
            c[j+1] = g[j] | (p[j] & c[j]);
            c[j+2] = g[j+1] | (p[j+1] & g[j]) | (p[j+1] & p[j] & c[j]);
            c[j+3] = g[j+2] | (p[j+2] & g[j+1]) | (p[j+2] & p[j+1] & g[j])
                   | (p[j+2] & p[j+1] & p[j] & c[j]);
            c[j+4] = g[j+3] | (p[j+3] & g[j+2]) | (p[j+3] & p[j+2] & g[j+1])
                   | (p[j+3] & p[j+2] & p[j+1] & g[j]) | (p[j+3] & p[j+2] & p[j+1] & p[j] & c[j]);
        end
        return {c[SW-1], c[SW], p ^ c[SW-1:0]};
    endfunction

    logic [STAGES-1:0] v_q, v_d, rdy, c_q, c_d, s_q, s_d, ci;
    logic [WIDTH-1:0]  a_q [STAGES-1];
    logic [WIDTH-1:0]  b_q [STAGES-1];
    logic [WIDTH-1:0]  r_q [STAGES];
    logic [WIDTH-1:0]  a_d [STAGES];
    logic [WIDTH-1:0]  b_d [STAGES];
    logic [WIDTH-1:0]  r_d [STAGES];
    logic              m_q, m_d;
    logic [SW+1:0]     sl;

    always_comb begin
        a_d[0] = a;
        b_d[0] = sub ? ~b : b;
        r_d[0] = '0;
        s_d[0] = sub;
        ci[0]  = carry_in ^ sub;
        v_d[0] = in_valid;
        for (int k = 1; k < STAGES; k++) begin
            a_d[k] = a_q[k-1];
            b_d[k] = b_q[k-1];
            r_d[k] = r_q[k-1];
            s_d[k] = s_q[k-1];
            ci[k]  = c_q[k-1];
            v_d[k] = v_q[k-1];
        end
        c_d = '0;
        sl  = '0;
        for (int k = 0; k < STAGES; k++) begin
            sl = cla_slice(a_d[k][k*SW +: SW], b_d[k][k*SW +: SW], ci[k]);
            r_d[k][k*SW +: SW] = sl[SW-1:0];
            c_d[k] = sl[SW];
        end
        m_d = sl[SW+1];
        // a stage can load unless it and every stage above it are full while the output stalls
        for (int k = 0; k < STAGES; k++)
            rdy[k] = out_ready || !(&(v_q | ~(ALL << k)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= '0;
            c_q <= '0;
            s_q <= '0;
            m_q <= 1'b0;
            for (int k = 0; k < STAGES; k++) r_q[k] <= '0;
            for (int k = 0; k < STAGES - 1; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (rdy[k]) begin
                    v_q[k] <= v_d[k];
                    r_q[k] <= r_d[k];
                    c_q[k] <= c_d[k];
                    s_q[k] <= s_d[k];
                end
            end
            for (int k = 0; k < STAGES - 1; k++) begin
                if (rdy[k]) begin
                    a_q[k] <= a_d[k];
                    b_q[k] <= b_d[k];
                end
            end
            if (rdy[STAGES-1]) m_q <= m_d;
        end
    end

    assign in_ready  = rdy[0];
    assign out_valid = v_q[STAGES-1];
    assign ans       = r_q[STAGES-1];
    assign carry_out = c_q[STAGES-1] ^ s_q[STAGES-1];
    assign overflow  = c_q[STAGES-1] ^ m_q;
    assign zero      = out_valid && (ans == '0);
endmodule

// File: tb/tb_pipelined_cla_adder.sv
// tb_pipelined_cla_adder: directed and random scoreboard bench for pipelined_cla_adder.
module tb_pipelined_cla_adder;
    localparam int STAGES = 4;

    logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, carry_in = 1'b0, sub = 1'b0, out_ready = 1'b1;
    logic        in_ready, out_valid, carry_out, overflow, zero;
    logic [31:0] a = '0, b = '0, ans;
    int          total = 0, bad = 0, cyc = 0, t;
    logic [34:0] sb[$];
    int          xq[$];
    logic        held = 1'b0, done = 1'b0;
    logic [34:0] hv;

    pipelined_cla_adder #(.WIDTH(32), .STAGES(STAGES)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .carry_in(carry_in), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
        .ans(ans), .carry_out(carry_out), .overflow(overflow), .zero(zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    // {ans, carry/borrow out, signed overflow, zero}
    function automatic logic [34:0] model(input logic [31:0] x, input logic [31:0] y,
                                          input logic ci, input logic s);
        logic [32:0] u;
        longint      sv;
        u  = s ? {1'b0, x} - {1'b0, y} - {32'b0, ci} : {1'b0, x} + {1'b0, y} + {32'b0, ci};
        sv = s ? longint'($signed(x)) - longint'($signed(y)) - longint'(ci)
               : longint'($signed(x)) + longint'($signed(y)) + longint'(ci);
        return {u[31:0], u[32], (sv > 64'sd2147483647) || (sv < -64'sd2147483648), u[31:0] == 32'd0};
    endfunction

    always @(negedge clk) begin
        if (!rst_n) held = 1'b0;
        else begin
            chk("in_ready", {63'b0, in_ready}, {63'b0, !(sb.size() == STAGES && !out_ready)});
            if (held) chk("stall_hold", {out_valid, ans, carry_out, overflow, zero}, {1'b1, hv});
            held = out_valid && !out_ready;
            hv   = {ans, carry_out, overflow, zero};
            if (out_valid && out_ready) begin
                xq.push_back(cyc);
                if (sb.size() == 0) chk("unexpected_out", {63'b0, out_valid}, 64'd0);
                else chk("result", {ans, carry_out, overflow, zero}, sb.pop_front());
            end
        end
    end

    task automatic send(input logic [31:0] x, input logic [31:0] y, input logic ci, input logic s);
        int n = 0;
        a = x; b = y; carry_in = ci; sub = s; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) chk("accept_timeout", {63'b0, in_ready}, 64'd1);
        @(posedge clk);
        sb.push_back(model(x, y, ci, s));
        #1;
    endtask

    task automatic drain();
        int n = 0;
        in_valid = 1'b0;
        while (sb.size() != 0 && n < 200) begin
            n++;
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        chk("drain", sb.size(), 0);
    endtask

    task automatic check_timing(input string tag, input int cnt, input int first, input int last);
        chk({tag, "_count"}, xq.size(), cnt);
        if (xq.size() > 0) begin
            chk({tag, "_first"}, xq[0], first);
            chk({tag, "_last"}, xq[xq.size()-1], last);
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_outputs", {out_valid, ans, carry_out, overflow, zero}, 64'd0);
        chk("rst_in_ready", {63'b0, in_ready}, 64'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("post_rst_in_ready", {63'b0, in_ready}, 64'd1);
        @(posedge clk); #1;

        xq.delete(); t = cyc;
        send(32'h0000FFFF, 32'h00000001, 1'b0, 1'b0);
        drain();
        check_timing("latency", 1, t + STAGES, t + STAGES);

        send(32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0);
        send(32'h80000000, 32'h00000001, 1'b0, 1'b1);
        send(32'h00000001, 32'h00000002, 1'b0, 1'b1);
        send(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0);
        send(32'h00000000, 32'h7FFFFFFF, 1'b1, 1'b1);
        send(32'h12345678, 32'h12345678, 1'b0, 1'b1);
        send(32'h00000000, 32'h00000000, 1'b1, 1'b1);
        send(32'h80000000, 32'h80000000, 1'b0, 1'b0);
        drain();

        xq.delete(); t = cyc;
        for (int i = 0; i < 100; i++)
            send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        drain();
        check_timing("throughput", 100, t + STAGES, t + STAGES + 99);

        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 10; i++)
                    send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                in_valid = 1'b0;
                done = 1'b1;
            end
            begin
                while (!done) begin
                    out_ready = 1'($urandom_range(0, 1));
                    @(posedge clk); #1;
                end
                out_ready = 1'b1;
            end
        join
        drain();

        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) send($urandom, $urandom, 1'b0, 1'($urandom_range(0, 1)));
        in_valid = 1'b0;
        rst_n = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("midrst_out_valid", {63'b0, out_valid}, 64'd0);
        chk("midrst_in_ready", {63'b0, in_ready}, 64'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        xq.delete(); t = cyc;
        send(32'hDEADBEEF, 32'h01010101, 1'b1, 1'b0);
        drain();
        check_timing("post_midrst", 1, t + STAGES, t + STAGES);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/pipelined_cla_adder.md
PIPELINED_CLA_ADDER -- requirements
Module: pipelined_cla_adder

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits; SHALL be a multiple of 4 times STAGES.
REQ-002 Parameter STAGES, default 4, pipeline depth; each stage SHALL compute WIDTH/STAGES result bits.
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  operand beat offered.
REQ-006 in_ready  output  1  block accepts a beat this cycle.
REQ-007 a  input  WIDTH  operand A.
REQ-008 b  input  WIDTH  operand B.
REQ-009 carry_in  input  1  carry (add) or borrow (subtract) in.
REQ-010 sub  input  1  0 = A+B+carry_in; 1 = A-B-carry_in.
REQ-011 out_valid  output  1  result beat presented.
REQ-012 out_ready  input  1  downstream accepts the result.
REQ-013 ans  output  WIDTH  result.
REQ-014 carry_out  output  1  add: carry out of MSB; subtract: borrow out (1 = A < B+carry_in unsigned).
REQ-015 overflow  output  1  signed two's-complement overflow of the operation.
REQ-016 zero  output  1  ans == 0.

Function
REQ-017 Operand accept SHALL occur on a cycle with in_valid && in_ready.
REQ-018 Result transfer SHALL occur on a cycle with out_valid && out_ready.
REQ-019 Effective B SHALL be ~b when sub=1 and b otherwise; initial carry c0 SHALL be carry_in ^ sub.
REQ-020 Within each stage, bits SHALL be processed in 4-bit carry-lookahead groups (generate/propagate per bit, group carries computed in parallel); groups within a stage SHALL chain by group carry.
REQ-021 Stage k SHALL register its result slice, its carry out, and the unprocessed upper operand bits, sub flag and carried-forward lower result bits.
REQ-022 Each stage SHALL hold a valid bit; stage k SHALL load when stage k+1 is empty or advancing (bubble-collapsing pipeline); the last stage advances on output transfer.
REQ-023 in_ready SHALL equal !valid[0] || (stage 0 advancing), combinationally; it SHALL NOT depend on in_valid.
REQ-024 Latency: with out_ready held 1, an accepted beat SHALL appear on out_valid exactly STAGES cycles later; throughput one beat per cycle.
REQ-025 Under backpressure (out_ready=0 with out_valid=1), ans/carry_out/overflow/zero SHALL remain stable until transfer; no beat SHALL be lost, duplicated or reordered.
REQ-026 With all stages full and out_ready=0, in_ready SHALL be 0; if out_ready rises, in_ready SHALL rise in that same cycle.
REQ-027 carry_out SHALL be the MSB carry for sub=0 and its inverse for sub=1.
REQ-028 overflow SHALL be carry into MSB XOR carry out of MSB (raw, before borrow inversion).
REQ-029 zero SHALL be derived from the registered final ans, not a separate pipeline.
REQ-030 Simultaneous accept and transfer on a full pipeline SHALL both complete in the same cycle.
REQ-031 Arithmetic SHALL wrap modulo 2^WIDTH; no saturation.

Reset
REQ-032 While rst_n=0: all stage valid bits SHALL be 0, out_valid=0, ans=0, carry_out=0, overflow=0, zero=0 (zero gated by out_valid is not required; value is 0).
REQ-033 in_ready SHALL be 1 during and immediately after reset.
REQ-034 Assertion mid-operation SHALL discard all in-flight beats immediately; no output transfer SHALL follow from pre-reset beats.

Verification (WIDTH=32, STAGES=4)
REQ-035 Add: a=0x0000FFFF, b=0x00000001, sub=0, carry_in=0 -> 4 cycles later ans=0x00010000, carry_out=0, overflow=0, zero=0.
REQ-036 Full ripple: a=0xFFFFFFFF, b=0x00000000, carry_in=1, sub=0 -> ans=0x00000000, carry_out=1, zero=1, overflow=0.
REQ-037 Subtract/overflow: a=0x80000000, b=0x00000001, sub=1, carry_in=0 -> ans=0x7FFFFFFF, carry_out=0, overflow=1; a=0x00000001, b=0x00000002, sub=1 -> ans=0xFFFFFFFF, carry_out=1.
REQ-038 Backpressure: stream 10 random beats with out_ready toggling pseudo-randomly -> 10 results in order matching a reference model, outputs stable while stalled, in_ready=0 only when 4 beats held and out_ready=0.
REQ-039 Throughput: 100 back-to-back beats, out_ready=1 -> out_valid continuously 1 from cycle 4 to cycle 103, all results correct.
REQ-040 Reset mid-stream: 3 beats in flight, rst_n pulsed low 1 cycle -> out_valid=0, in_ready=1, next accepted beat emerges alone after 4 cycles.
